// File: rtl/mem_responder.sv
// Single-outstanding memory responder: word-addressed array at BASE answered over a
// valid/ready request/response channel after a fixed LATENCY, with byte-masked writes.
module mem_responder #(
  parameter int          ADDR_W     = 64,
  parameter int          DATA_W     = 64,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_wen,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;

  logic [ADDR_W-1:0]     addr_p0;
  logic                  wen_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic [MASK_W-1:0]     wmask_p0;

  logic [DATA_W-1:0]     mem [0:DEPTH-1];

  logic [ADDR_W-1:0]     acc_addr;
  logic                  acc_wen;
  logic [DATA_W-1:0]     acc_wdata;
  logic [MASK_W-1:0]     acc_wmask;
  logic [ADDR_W-1:0]     off;
  logic [ADDR_W-1:0]     word;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_err;
  logic                  accept;
  logic                  commit;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [MASK_W-1:0] mask
  );
    logic [DATA_W-1:0] r;
    r = old_word;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = (state == IDLE) && req_valid;
  // The access happens on the edge that enters RESP; with LATENCY=0 that is the
  // acceptance edge itself, so the live request fields are used instead of the latch.
  assign commit    = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1));

  always_comb begin
    acc_addr  = addr_p0;
    acc_wen   = wen_p0;
    acc_wdata = wdata_p0;
    acc_wmask = wmask_p0;
    if (state == IDLE) begin
      acc_addr  = req_addr;
      acc_wen   = req_wen;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end
  end

  assign off     = acc_addr - ADDR_W'(BASE);
  assign word    = off >> 3;
  assign acc_idx = word[DEPTH_LOG2-1:0];
  assign acc_err = (acc_addr < ADDR_W'(BASE)) || ((word >> DEPTH_LOG2) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cnt   <= 4'(LATENCY);
            state <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || acc_wen) ? '0 : mem[acc_idx];
      end
    end
  end

  // Request capture stage (data only, not reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= req_addr;
      wen_p0   <= req_wen;
      wdata_p0 <= req_wdata;
      wmask_p0 <= req_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && !rst && acc_wen && !acc_err) begin
      mem[acc_idx] <= merge_bytes(mem[acc_idx], acc_wdata, acc_wmask);
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's fetch and load/store ports: the slave end of a valid/ready request/response channel issued by the PC/LSU.
- Holds a word-addressed internal array mapped at BASE and answers one outstanding request at a time after a programmable latency.
- Supports reads and byte-masked writes, and flags accesses outside the mapped window.
- Replaces the DPI vmem path so fetch and data accesses can be exercised in pure RTL.

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, data width (fixed 64; mask width DATA_W/8 = 8)
- DEPTH_LOG2, 12, log2 of the number of 64-bit words in the array
- BASE, 64'h0000000080000000, byte address of word 0
- LATENCY, 2, wait cycles between acceptance and response (0..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_W  byte address; bits [2:0] ignored
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  DATA_W  write data
- req_wmask  in  8  byte enables; bit i selects byte i
- resp_valid  out  1  response present
- resp_ready  in  1  requester takes the response
- resp_rdata  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  address outside [BASE, BASE + 8*2^DEPTH_LOG2)

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Handshake on req_valid && req_ready at a rising edge: latch addr/wen/wdata/wmask and load counter = LATENCY.
  - Next state is WAIT if LATENCY > 0, else RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; at counter == 1 the next state is RESP.
  - Acceptance at cycle t gives resp_valid at cycle t+1+LATENCY.
- Entry to RESP (the same edge that sets resp_valid) performs the access:
  - Range check: idx = (addr - BASE) >> 3, computed in ADDR_W bits unsigned. Error if addr < BASE or idx >= 2^DEPTH_LOG2.
  - Error: resp_err = 1, resp_rdata = 0, no array update.
  - Read: resp_rdata = mem[idx], resp_err = 0.
  - Write: for each i with wmask[i] = 1, byte i of mem[idx] takes wdata byte i; other bytes are unchanged. resp_rdata = 0, resp_err = 0.
  - Write with wmask = 0: no change, normal response.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until the handshake. req_ready = 0.
  - On resp_valid && resp_ready: go to IDLE and clear resp_valid, resp_rdata and resp_err on that edge.
- No back-to-back acceptance: at most one request every LATENCY+2 cycles. This is a deliberate simplification; there is no pipelining.
- req_valid while not ready: ignored. The requester must hold the request; the responder does not latch it.
- Request fields changing after acceptance: no effect (the latched copy is used).
- Reset mid-operation:
  - In WAIT: the pending write is dropped and the array is unchanged.
  - In RESP: an already-committed write persists; the response is discarded.
- Read-after-write to the same word in successive transactions returns the merged data.

Test Plan:
- Reset, then read 0x80000000 with LATENCY=2 after preloading mem[0]=0x1122334455667788 via backdoor → req accepted at t0, resp_valid at t0+3, rdata=0x1122334455667788, err=0.
- Write 0x80000008, wdata=0xAAAAAAAAAAAAAAAA, wmask=0x0F over existing 0x0 → write response rdata=0; subsequent read returns 0x00000000AAAAAAAA.
- Read 0x7FFFFFF8 and 0x80008000 (DEPTH_LOG2=12) → resp_err=1, rdata=0; a write with mask 0xFF to 0x80008000 leaves mem[0] unchanged.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid/rdata stable, req_ready=0, a new req_valid is not accepted. Raise resp_ready → IDLE next cycle, req_ready=1.
- LATENCY=0 → resp_valid exactly 1 cycle after acceptance.
- Assert rst during WAIT of a write to 0x80000010 (mem[2]=0x5) → outputs return to reset values immediately (async), and mem[2] still reads 0x5 after reset release.
